mdu: RTL and testbench

Iterative multiply/divide unit in the EX stage, beside the ALU and fed the same register-file operands A and B. It executes MULT/MULTU/DIV/DIVU over multiple cycles and holds the architectural HI/LO registers. It also takes MTHI/MTLO writes. The `hi`/`lo` outputs feed the MFHI/MFLO leg of the EX result mux downstream of the ALU. `busy` is the stall source for the hazard/control logic.

---
 rtl/mdu_if.sv | 16 +
 rtl/mdu.sv | 156 +++++++++++++++
 tb/tb_mdu.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Request/response bundle between EX-stage control and the multiply/divide unit.
interface mdu_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, A, B, input busy, done, hi, lo);
    modport slave  (input start, op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// One bit per cycle on magnitudes; sign fix-up and register write happen in FIN.
module mdu #(
    parameter int unsigned WIDTH = 32
) (
    input logic  clk,
    input logic  rstn,
    mdu_if.slave bus
);
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [DW:0]      div_shift;
    logic [WIDTH:0]   div_trial;
    logic [DW-1:0]    prod;
    logic [WIDTH-1:0] quot, rem;

    // Operand magnitudes and one-step datapath results
    always_comb begin
        is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        a_neg     = is_signed & bus.A[WIDTH-1];
        b_neg     = is_signed & bus.B[WIDTH-1];
        a_mag     = a_neg ? -bus.A : bus.A;
        b_mag     = b_neg ? -bus.B : bus.B;
        mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, 1'b0};
        div_trial = div_shift[DW:WIDTH] - {1'b0, opb_q};
        prod      = neg_q ? -acc_q : acc_q;
        quot      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = rem_neg_q ? -acc_q[DW-1:WIDTH] : acc_q[DW-1:WIDTH];
    end

    // Next-state and register updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (!bus.op[2]) begin
                        is_div_d  = bus.op[1];
                        acc_d     = {{WIDTH{1'b0}}, bus.op[1] ? a_mag : b_mag};
                        opb_d     = bus.op[1] ? b_mag : a_mag;
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        dz_d      = (bus.B == '0);
                        cnt_d     = '0;
                        state_d   = S_RUN;
                    end else if (bus.op == OP_MTHI) begin
                        hi_d = bus.A;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.A;
                    end
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    // Restoring step: keep the trial remainder only when it did not go negative
                    acc_d = div_trial[WIDTH] ? div_shift[DW-1:0]
                                             : {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (is_div_q) begin
                    lo_d = dz_q ? '1 : quot;
                    hi_d = rem;
                end else begin
                    {hi_d, lo_d} = prod;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: cycle-level reference model compared every cycle, plus literal result checks.
module tb_mdu;
    localparam int unsigned WIDTH = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(WIDTH)) bus ();
    mdu #(.WIDTH(WIDTH)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;
    logic chk_en = 1'b0;

    function void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endfunction

    // Architectural result of one mult/div as {HI, LO}
    function automatic logic [63:0] ref_res(logic [2:0] o, logic [31:0] a, logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2, 3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 3'd2) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    return {32'(sr), 32'(sq)};
                end
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Reference model: accepted mult/div resolves 33 edges later
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 1) begin
                m_left <= m_left - 1;
            end else if (m_left == 1) begin
                m_left <= 0;
                m_hi   <= m_res[63:32];
                m_lo   <= m_res[31:0];
                m_done <= 1'b1;
                m_busy <= 1'b0;
            end else if (bus.start) begin
                if (!bus.op[2]) begin
                    m_res  <= ref_res(bus.op, bus.A, bus.B);
                    m_left <= 33;
                    m_busy <= 1'b1;
                end else if (bus.op == 3'd4) begin
                    m_hi <= bus.A;
                end else if (bus.op == 3'd5) begin
                    m_lo <= bus.A;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 32'(bus.busy), 32'(m_busy));
            check("cyc_done", 32'(bus.done), 32'(m_done));
            check("cyc_hi", bus.hi, m_hi);
            check("cyc_lo", bus.lo, m_lo);
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'($urandom); bus.A = $urandom; bus.B = $urandom;
    endtask

    task automatic wait_done(output int n, output int nb);
        n = 0; nb = 0;
        while (!bus.done && n < 50) begin
            if (bus.busy) nb++;
            @(negedge clk);
            n++;
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, eh, el;
    } vec_t;
    vec_t vecs [0:7];

    initial begin
        int n, nb, cnt;
        bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
        vecs = '{
            '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
            '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
            '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
            '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
            '{3'd3, 32'h0000_0007, 32'hFFFF_FFF9, 32'h0000_0007, 32'h0000_0000},
            '{3'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF},
            '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
            '{3'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF}
        };

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Directed results with fixed latency
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(n, nb);
            check($sformatf("v%0d_latency", i), 32'(n), 32'd33);
            check($sformatf("v%0d_busycyc", i), 32'(nb), 32'd33);
            check($sformatf("v%0d_hi", i), bus.hi, vecs[i].eh);
            check($sformatf("v%0d_lo", i), bus.lo, vecs[i].el);
            check($sformatf("v%0d_model_hi", i), m_hi, vecs[i].eh);
            check($sformatf("v%0d_model_lo", i), m_lo, vecs[i].el);
        end

        // MTHI/MTLO while busy are dropped
        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'hCAFE_F00D;
        @(negedge clk);
        bus.op = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n, nb);
        check("mtbusy_hi", bus.hi, 32'hFFFF_FFFF);
        check("mtbusy_lo", bus.lo, 32'hFFFF_FFEB);

        // MTHI/MTLO in idle, back to back
        bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'hCAFE_F00D;
        @(negedge clk);
        check("mthi_hi", bus.hi, 32'hCAFE_F00D);
        check("mthi_done", 32'(bus.done), 32'd0);
        bus.op = 3'd5;
        @(negedge clk);
        check("mtlo_lo", bus.lo, 32'hCAFE_F00D);
        check("mtlo_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;

        // Reset mid-multiply aborts without done
        issue(3'd0, $urandom, $urandom);
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        rstn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        check("abort_nodone", 32'(cnt), 32'd0);

        // New MULTU accepted in the done cycle
        issue(3'd1, 32'd3, 32'd5);
        wait_done(n, nb);
        check("b2b_first_lo", bus.lo, 32'd15);
        issue(3'd1, 32'h0001_0000, 32'h0001_0000);
        wait_done(n, nb);
        check("b2b_latency", 32'(n), 32'd33);
        check("b2b_hi", bus.hi, 32'd1);
        check("b2b_lo", bus.lo, 32'd0);

        // Random traffic, including starts and MTHI/MTLO while busy
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom % 3 == 0);
            bus.op    = 3'($urandom);
            bus.A     = pick();
            bus.B     = pick();
            @(negedge clk);
        end
        bus.start = 1'b0;
        n = 0;
        while ((m_busy || bus.busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", 32'(bus.busy), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
